// File: rtl/return_address_stack.sv
// Return-address LIFO for CALL/RET. Pop is read-then-pop: top_data shows the
// entry being popped in the request cycle. Overflow and underflow flags are sticky.
module return_address_stack #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stack_write_enable,
   input  logic                       stack_control,
   input  logic [DATA_WIDTH-1:0]      push_data,
   output logic [DATA_WIDTH-1:0]      top_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = AW + 1;
   localparam logic [SW-1:0] DEPTH_C = SW'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [SW-1:0]         r_sp;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_push_req;
   logic                  w_pop_req;
   logic [SW-1:0]         w_sp_dec;
   logic [AW-1:0]         w_top_idx;
   logic [AW-1:0]         w_wr_idx;

   assign w_empty    = (r_sp == '0);
   assign w_full     = (r_sp == DEPTH_C);
   assign w_push_req = stack_write_enable && !stack_control;
   assign w_pop_req  = stack_write_enable &&  stack_control;
   assign w_sp_dec   = r_sp - 1'b1;
   assign w_top_idx  = w_sp_dec[AW-1:0];
   assign w_wr_idx   = r_sp[AW-1:0];

   // Storage is not reset; reset still blocks the write so a colliding push is discarded.
   always_ff @(posedge clk) begin
      if (!rst && w_push_req && !w_full) begin
         r_mem[w_wr_idx] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp        <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_req) begin
            if (w_full) begin
               r_overflow <= 1'b1;
            end else begin
               r_sp <= r_sp + 1'b1;
            end
         end else if (w_pop_req) begin
            if (w_empty) begin
               r_underflow <= 1'b1;
            end else begin
               r_sp <= w_sp_dec;
            end
         end
      end
   end

   // Masked to zero when empty so a popped-away entry is never visible.
   assign top_data  = w_empty ? '0 : r_mem[w_top_idx];
   assign count     = r_sp;
   assign empty     = w_empty;
   assign full      = w_full;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule
